mp2d_act_mon: RTL and testbench
===============================

MP2D_ACT_MON -- requirements
Module: mp2d_act_mon

Interface
REQ-001 SHALL have parameter WIDTH, default 14: width of the observed vector, matching the v14 output bus of the upstream logic.
REQ-002 SHALL have parameter CNT_W, default 20: width of the total-toggle accumulator.
REQ-003 SHALL have parameter WIN_W, default 16: width of the window-length field.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: pulse that begins a measurement window; honoured only in IDLE.
REQ-007 SHALL have port win_len, input, WIN_W: number of transitions to count; sampled on an accepted start.
REQ-008 SHALL have port in_valid, input, 1: in_vec carries a new sample this cycle.
REQ-009 SHALL have port in_vec, input, WIDTH: observed vector (v14.0..v14.13).
REQ-010 SHALL have port busy, output, 1: high in PRIME and ACCUM.
REQ-011 SHALL have port res_valid, output, 1: result available.
REQ-012 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port res_total, output, CNT_W: total bit toggles in the window.
REQ-014 SHALL have port res_peak, output, $clog2(WIDTH+1): maximum Hamming distance between consecutive samples.

Function
REQ-015 SHALL implement FSM states IDLE, PRIME, ACCUM, HOLD.
- IDLE->PRIME on start.
- PRIME->ACCUM on the first in_valid (captures reference sample, counts nothing).
- ACCUM->HOLD when the transition counter reaches the latched length.
- HOLD->IDLE on res_valid & res_ready.
REQ-016 SHALL, per in_valid in ACCUM: add popcount(in_vec ^ prev) to total, update peak = max(peak, popcount), set prev <= in_vec, and increment the transition count.
REQ-017 SHALL ignore cycles without in_valid; they are not transitions.
REQ-018 SHALL treat a latched win_len of 0 as 1.
REQ-019 SHALL saturate total at all-ones, with no wrap-around.
REQ-020 SHALL assert res_valid the cycle after the final counted sample, holding res_total and res_peak stable until the handshake completes; res_ready is ignored while res_valid is low.
REQ-021 SHALL ignore start while not in IDLE, including a start coincident with a HOLD handshake.
REQ-022 SHALL clear accumulators when start is accepted, so a new window never inherits old counts.
REQ-023 SHALL have a transition latency from sample to accumulator of exactly 1 cycle, with no combinational path from in_vec to any output.

Reset
REQ-024 SHALL, on rst_n low: state=IDLE; busy=0, res_valid=0, res_total=0, res_peak=0; prev and counters cleared.
REQ-025 SHALL abandon any in-progress window on mid-window reset; no partial result is ever presented.

Configuration
REQ-026 SHALL, with ACT_MON_PERBIT_EN defined, add per-bit 16-bit saturating toggle counters, plus inputs bit_sel[$clog2(WIDTH)-1:0] and output bit_cnt[15:0]; the counters are cleared on start and bit_cnt is registered and valid in HOLD.
REQ-027 SHALL, without ACT_MON_PERBIT_EN, omit those ports and counters entirely.

Structure
REQ-028 SHALL place the FSM state enum and default WIDTH/CNT_W/WIN_W constants in package mp2d_act_mon_pkg.
REQ-029 SHALL implement popcount in sub-module mp2d_act_popcount (WIDTH-bit input, count output, combinational).

Verification
REQ-030 SHALL verify basic window: start with win_len=3, then samples 0x0000, 0x3FFF, 0x0000, 0x0001 -> res_total=29, res_peak=14.
REQ-031 SHALL verify gapped valid: same stream with in_valid low for 5 cycles between samples -> identical result.
REQ-032 SHALL verify backpressure: res_ready held low 10 cycles -> res_valid and values stable; the handshake returns the FSM to IDLE the next cycle.
REQ-033 SHALL verify saturation: CNT_W=4, win_len=2, samples 0x0000, 0x3FFF, 0x0000 -> res_total=15.
REQ-034 SHALL verify mid-window reset: assert rst_n low after 2 samples, then a fresh window with win_len=1 and samples 0x0001, 0x0003 -> res_total=1, res_peak=1.
REQ-035 SHALL verify start ignored in ACCUM and in HOLD: no counter clear and no restart.

Source files
------------

// File: rtl/mp2d_act_mon_pkg.sv
// Shared constants and FSM state encoding for the mp2d activity monitor.
package mp2d_act_mon_pkg;

    localparam int DEF_WIDTH = 14;
    localparam int DEF_CNT_W = 20;
    localparam int DEF_WIN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2,
        ST_HOLD  = 2'd3
    } act_state_t;

endpackage

// File: rtl/mp2d_act_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module mp2d_act_popcount #(
    parameter int WIDTH = 14,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + CW'(in_vec[i]);
        end
    end

endmodule

// File: rtl/mp2d_act_mon.sv
// Switching-activity monitor: totals and peaks bit toggles between consecutive samples.
// Define ACT_MON_PERBIT_EN to add per-bit toggle counters with bit_sel/bit_cnt.
module mp2d_act_mon
    import mp2d_act_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIN_W-1:0]             win_len,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_vec,
    output logic                         busy,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [CNT_W-1:0]             res_total,
    output logic [$clog2(WIDTH+1)-1:0]   res_peak
`ifdef ACT_MON_PERBIT_EN
    ,
    input  logic [$clog2(WIDTH)-1:0]     bit_sel,
    output logic [15:0]                  bit_cnt
`endif
);

    localparam int PW = $clog2(WIDTH + 1);

    act_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] total;
    logic [PW-1:0]    peak;
    logic [PW-1:0]    pc;
    logic [WIN_W-1:0] len;
    logic [WIN_W-1:0] tcnt;
    logic [WIN_W-1:0] tcnt_nx;
    logic [CNT_W:0]   sum;

    assign diff = in_vec ^ prev;

    mp2d_act_popcount #(.WIDTH(WIDTH)) u_pop (
        .in_vec (diff),
        .count  (pc)
    );

    // One extra carry bit detects overflow so the total clamps instead of wrapping.
    always_comb begin
        sum     = {1'b0, total} + (CNT_W + 1)'(pc);
        tcnt_nx = tcnt + WIN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            prev  <= '0;
            total <= '0;
            peak  <= '0;
            len   <= '0;
            tcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len   <= (win_len == '0) ? WIN_W'(1) : win_len;
                        total <= '0;
                        peak  <= '0;
                        tcnt  <= '0;
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (in_valid) begin
                        prev  <= in_vec;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        total <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                        if (pc > peak) peak <= pc;
                        prev  <= in_vec;
                        tcnt  <= tcnt_nx;
                        if (tcnt_nx == len) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_PRIME) || (state == ST_ACCUM);
    assign res_valid = (state == ST_HOLD);
    assign res_total = total;
    assign res_peak  = peak;

`ifdef ACT_MON_PERBIT_EN
    logic [15:0] bit_ctr [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) bit_ctr[i] <= '0;
            bit_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                for (int unsigned i = 0; i < WIDTH; i++) bit_ctr[i] <= '0;
            end else if (state == ST_ACCUM && in_valid) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (diff[i] && bit_ctr[i] != '1) bit_ctr[i] <= bit_ctr[i] + 16'd1;
                end
            end
            bit_cnt <= (32'(bit_sel) < WIDTH) ? bit_ctr[bit_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_mp2d_act_mon.sv
// Self-checking bench for mp2d_act_mon (default build) with a scoreboard of expected results.
module tb_mp2d_act_mon;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        in_valid;
    logic [13:0] in_vec;
    logic        res_ready;

    logic        busy, res_valid;
    logic [19:0] res_total;
    logic [3:0]  res_peak;

    logic        s_busy, s_valid;
    logic [3:0]  s_total;
    logic [3:0]  s_peak;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned tot;
        int unsigned pk;
        int unsigned sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mp2d_act_mon dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_total(res_total), .res_peak(res_peak)
    );

    mp2d_act_mon #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(s_busy), .res_valid(s_valid),
        .res_ready(res_ready), .res_total(s_total), .res_peak(s_peak)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        win_len = 16'(len);
        cyc();
        start   = 1'b0;
    endtask

    task automatic send(input logic [13:0] v, input int gap);
        in_valid = 1'b1;
        in_vec   = v;
        cyc();
        in_valid = 1'b0;
        in_vec   = 14'($urandom);
        repeat (gap) cyc();
    endtask

    task automatic collect(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    function automatic int unsigned popc(input logic [13:0] v);
        int unsigned n = 0;
        for (int i = 0; i < 14; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; win_len = '0; in_valid = 1'b0; in_vec = '0; res_ready = 1'b0;
        repeat (3) cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
        total++; if (res_total !== 20'd0) begin bad++; $display("FAIL reset_total: got %0d want 0", res_total); end
        total++; if (res_peak !== 4'd0) begin bad++; $display("FAIL reset_peak: got %0d want 0", res_peak); end
        rst_n = 1'b1;
        cyc();
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got busy=%0b valid=%0b want 0/0", busy, res_valid); end
    endtask

    task automatic test_basic(input int gap, input string nm);
        exp_t e;
        bit got;
        sb.push_back('{29, 14, 15});
        do_start(3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %0b want 1", nm, busy); end
        send(14'h0000, gap); send(14'h3FFF, gap); send(14'h0000, gap); send(14'h0001, 0);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL %s_latency: got valid=%0b want 1", nm, res_valid); end
        collect(got);
        total++; if (!got) begin bad++; $display("FAIL %s_timeout: got no res_valid want res_valid", nm); end
        e = sb.pop_front();
        total++; if (res_total !== 20'(e.tot)) begin bad++; $display("FAIL %s_total: got %0d want %0d", nm, res_total, e.tot); end
        total++; if (res_peak !== 4'(e.pk)) begin bad++; $display("FAIL %s_peak: got %0d want %0d", nm, res_peak, e.pk); end
        total++; if (s_total !== 4'(e.sat)) begin bad++; $display("FAIL %s_sat_total: got %0d want %0d", nm, s_total, e.sat); end
        handshake();
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_release: got valid=%0b busy=%0b want 0/0", nm, res_valid, busy); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        sb.push_back('{29, 14, 15});
        do_start(3);
        send(14'h0000, 0); send(14'h3FFF, 0); send(14'h0000, 0); send(14'h0001, 0);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (res_valid !== 1'b1 || res_total !== 20'(e.tot) || res_peak !== 4'(e.pk)) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%0b total=%0d peak=%0d want 1/%0d/%0d", i, res_valid, res_total, res_peak, e.tot, e.pk);
            end
            cyc();
        end
        handshake();
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release: got valid=%0b busy=%0b want 0/0", res_valid, busy); end
    endtask

    task automatic test_saturation();
        exp_t e;
        bit got;
        sb.push_back('{28, 14, 15});
        do_start(2);
        send(14'h0000, 0); send(14'h3FFF, 0); send(14'h0000, 0);
        collect(got);
        total++; if (!got) begin bad++; $display("FAIL sat_timeout: got no res_valid want res_valid"); end
        e = sb.pop_front();
        total++; if (s_total !== 4'(e.sat)) begin bad++; $display("FAIL sat_total: got %0d want %0d", s_total, e.sat); end
        total++; if (s_peak !== 4'(e.pk)) begin bad++; $display("FAIL sat_peak: got %0d want %0d", s_peak, e.pk); end
        total++; if (res_total !== 20'(e.tot)) begin bad++; $display("FAIL sat_wide_total: got %0d want %0d", res_total, e.tot); end
        handshake();
    endtask

    task automatic test_midreset();
        exp_t e;
        bit got;
        do_start(3);
        send(14'h0000, 0); send(14'h3FFF, 0);
        #2 rst_n = 1'b0;
        #3;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0 || res_total !== 20'd0) begin
            bad++; $display("FAIL midrst_clear: got busy=%0b valid=%0b total=%0d want 0/0/0", busy, res_valid, res_total);
        end
        rst_n = 1'b1;
        cyc();
        sb.push_back('{1, 1, 1});
        do_start(1);
        send(14'h0001, 0); send(14'h0003, 0);
        collect(got);
        total++; if (!got) begin bad++; $display("FAIL midrst_timeout: got no res_valid want res_valid"); end
        e = sb.pop_front();
        total++; if (res_total !== 20'(e.tot)) begin bad++; $display("FAIL midrst_total: got %0d want %0d", res_total, e.tot); end
        total++; if (res_peak !== 4'(e.pk)) begin bad++; $display("FAIL midrst_peak: got %0d want %0d", res_peak, e.pk); end
        handshake();
    endtask

    task automatic test_start_ignored();
        exp_t e;
        sb.push_back('{8, 4, 8});
        do_start(2);
        send(14'h0000, 0); send(14'h000F, 0);
        do_start(5);
        total++; if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL ign_accum: got busy=%0b valid=%0b want 1/0", busy, res_valid); end
        send(14'h00FF, 0);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ign_len_kept: got valid=%0b want 1", res_valid); end
        do_start(4);
        e = sb.pop_front();
        total++; if (res_valid !== 1'b1 || res_total !== 20'(e.tot)) begin bad++; $display("FAIL ign_hold: got valid=%0b total=%0d want 1/%0d", res_valid, res_total, e.tot); end
        total++; if (res_peak !== 4'(e.pk)) begin bad++; $display("FAIL ign_peak: got %0d want %0d", res_peak, e.pk); end
        start = 1'b1; res_ready = 1'b1; win_len = 16'd2;
        cyc();
        start = 1'b0; res_ready = 1'b0;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL ign_hs_start: got busy=%0b valid=%0b want 0/0", busy, res_valid); end
    endtask

    task automatic test_zero_len();
        exp_t e;
        sb.push_back('{3, 3, 3});
        do_start(0);
        send(14'h0000, 0); send(14'h0007, 0);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL zlen_valid: got %0b want 1", res_valid); end
        e = sb.pop_front();
        total++; if (res_total !== 20'(e.tot) || res_peak !== 4'(e.pk)) begin bad++; $display("FAIL zlen_result: got %0d/%0d want %0d/%0d", res_total, res_peak, e.tot, e.pk); end
        handshake();
    endtask

    task automatic test_random();
        logic [13:0] smp[$];
        exp_t e;
        bit got;
        int unsigned t = 0, p = 0, d;
        for (int i = 0; i < 7; i++) smp.push_back(14'($urandom));
        for (int i = 1; i < 7; i++) begin
            d = popc(smp[i] ^ smp[i-1]);
            t += d;
            if (d > p) p = d;
        end
        sb.push_back('{t, p, (t > 15) ? 15 : t});
        do_start(6);
        foreach (smp[i]) send(smp[i], $urandom_range(0, 2));
        collect(got);
        total++; if (!got) begin bad++; $display("FAIL rand_timeout: got no res_valid want res_valid"); end
        e = sb.pop_front();
        total++; if (res_total !== 20'(e.tot)) begin bad++; $display("FAIL rand_total: got %0d want %0d", res_total, e.tot); end
        total++; if (res_peak !== 4'(e.pk)) begin bad++; $display("FAIL rand_peak: got %0d want %0d", res_peak, e.pk); end
        total++; if (s_total !== 4'(e.sat)) begin bad++; $display("FAIL rand_sat: got %0d want %0d", s_total, e.sat); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(5, "gapped");
        test_backpressure();
        test_saturation();
        test_midreset();
        test_start_ignored();
        test_zero_len();
        repeat (3) test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
